// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared encodings for the irrigation zone scheduler
package irrigation_pkg;
   localparam int LEVEL_W = 3;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_WATER   = 3'd2,
      S_PURGE   = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;
   typedef enum logic {
      Z_SPRINKLER = 1'b0,
      Z_DRIPPER   = 1'b1
   } zone_t;
endpackage

// File: rtl/irrigation_tick_timer.sv
// irrigation_tick_timer: tick-enabled saturating counter with synchronous clear
module irrigation_tick_timer #(
   parameter int TIMER_W = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_clear,
   output logic [TIMER_W-1:0] o_count
);
   logic [TIMER_W-1:0] r_count;
   // count ticks, hold at all-ones, restart on clear
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_count <= '0;
      else if (i_clear) r_count <= '0;
      else if (i_tick && r_count != '1) r_count <= r_count + 1'b1;
   end
   assign o_count = r_count;
endmodule

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: round-robin pump/valve sequencer with low-tank lockout
module irrigation_zone_scheduler
   import irrigation_pkg::*;
#(
   parameter int SETTLE_TICKS    = 2,
   parameter int MAX_WATER_TICKS = 30,
   parameter int PURGE_TICKS     = 2,
   parameter int LOW_LEVEL       = 1,
   parameter int RESUME_LEVEL    = 3,
   parameter int TIMER_W         = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic [LEVEL_W-1:0] i_level,
   input  logic               i_req_sprinkler,
   input  logic               i_req_dripper,
   output logic               o_valve_sprinkler,
   output logic               o_valve_dripper,
   output logic               o_pump_on,
   output logic               o_dripper_active,
   output logic               o_low_water,
   output logic               o_zone_done,
   output logic [2:0]         o_state
);
   localparam logic [TIMER_W:0]   L_SETTLE = (TIMER_W+1)'(SETTLE_TICKS);
   localparam logic [TIMER_W:0]   L_WATER  = (TIMER_W+1)'(MAX_WATER_TICKS);
   localparam logic [TIMER_W:0]   L_PURGE  = (TIMER_W+1)'(PURGE_TICKS);
   localparam logic [LEVEL_W-1:0] L_LOW    = LEVEL_W'(LOW_LEVEL);
   localparam logic [LEVEL_W-1:0] L_RESUME = LEVEL_W'(RESUME_LEVEL);

   state_t             r_state, w_next;
   zone_t              r_grant, r_last, w_grant_new;
   logic               r_low, r_done;
   logic [TIMER_W-1:0] w_count;
   logic [TIMER_W:0]   w_next_cnt;
   logic               w_req_g, w_done, w_active;

   irrigation_tick_timer #(.TIMER_W(TIMER_W)) u_timer (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_tick  (i_tick),
      .i_clear (w_next != r_state),
      .o_count (w_count)
   );

   // the value the timer would hold after this cycle's tick, so a limit is
   // honoured on the same edge that counts the final tick
   assign w_next_cnt  = {1'b0, w_count} + {{TIMER_W{1'b0}}, i_tick};
   assign w_req_g     = (r_grant == Z_SPRINKLER) ? i_req_sprinkler : i_req_dripper;
   assign w_grant_new = (i_req_sprinkler && i_req_dripper)
                        ? ((r_last == Z_SPRINKLER) ? Z_DRIPPER : Z_SPRINKLER)
                        : (i_req_dripper ? Z_DRIPPER : Z_SPRINKLER);
   assign w_done      = (r_state == S_PURGE) && (w_next_cnt >= L_PURGE);

   // next-state: a dropped request or low tank always beats the timer
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:    w_next = r_low ? S_LOCKOUT
                           : (i_req_sprinkler || i_req_dripper) ? S_SETTLE : S_IDLE;
         S_SETTLE:  w_next = (!w_req_g || r_low) ? S_PURGE
                           : (w_next_cnt >= L_SETTLE) ? S_WATER : S_SETTLE;
         S_WATER:   w_next = (!w_req_g || r_low || w_next_cnt >= L_WATER) ? S_PURGE : S_WATER;
         S_PURGE:   w_next = w_done ? (r_low ? S_LOCKOUT : S_IDLE) : S_PURGE;
         S_LOCKOUT: w_next = r_low ? S_LOCKOUT : S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // state, arbitration memory, completion pulse and hysteresis flag
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_grant <= Z_SPRINKLER;
         r_last  <= Z_DRIPPER;
         r_done  <= 1'b0;
         r_low   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_next == S_SETTLE) r_grant <= w_grant_new;
         if (w_done) r_last <= r_grant;
         r_done  <= w_done;
         r_low   <= (i_level <= L_LOW) ? 1'b1 : (i_level >= L_RESUME) ? 1'b0 : r_low;
      end
   end

   assign w_active          = (r_state == S_SETTLE) || (r_state == S_WATER) || (r_state == S_PURGE);
   assign o_valve_sprinkler = w_active && (r_grant == Z_SPRINKLER);
   assign o_valve_dripper   = w_active && (r_grant == Z_DRIPPER);
   assign o_dripper_active  = o_valve_dripper;
   assign o_pump_on         = (r_state == S_WATER);
   assign o_low_water       = r_low;
   assign o_zone_done       = r_done;
   assign o_state           = r_state;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb_irrigation_zone_scheduler: directed plan plus randomized checks against a behavioural model
module tb_irrigation_zone_scheduler;
   localparam int LOW = 1, RESUME = 3;
   logic       i_clock = 1'b0, i_reset = 1'b0, i_tick = 1'b0;
   logic [2:0] i_level = 3'd5;
   logic       i_req_sprinkler = 1'b0, i_req_dripper = 1'b0;
   logic       o_valve_sprinkler, o_valve_dripper, o_pump_on, o_dripper_active;
   logic       o_low_water, o_zone_done;
   logic [2:0] o_state;
   int         total = 0, bad = 0;
   bit         m_low = 1'b0;
   int         m_last = 1;

   irrigation_zone_scheduler dut (
      .i_clock           (i_clock),
      .i_reset           (i_reset),
      .i_tick            (i_tick),
      .i_level           (i_level),
      .i_req_sprinkler   (i_req_sprinkler),
      .i_req_dripper     (i_req_dripper),
      .o_valve_sprinkler (o_valve_sprinkler),
      .o_valve_dripper   (o_valve_dripper),
      .o_pump_on         (o_pump_on),
      .o_dripper_active  (o_dripper_active),
      .o_low_water       (o_low_water),
      .o_zone_done       (o_zone_done),
      .o_state           (o_state)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; the hysteresis model follows the level presented during the cycle
   task automatic step();
      logic [2:0] lv;
      lv = i_level;
      @(posedge i_clock);
      if (int'(lv) <= LOW) m_low = 1'b1;
      else if (int'(lv) >= RESUME) m_low = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b0; i_req_sprinkler = 1'b0; i_req_dripper = 1'b0; i_tick = 1'b0;
      m_low = 1'b0;
      repeat (2) @(posedge i_clock);
      #1 i_reset = 1'b1;
   endtask

   // run until one grant completes; reports the zone that held a valve and tick totals
   task automatic run_grant(input bit rnd, output int zone, output int pt, output int vt, output bit ok);
      zone = -1; pt = 0; vt = 0; ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         i_tick = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_pump_on && i_tick) pt++;
         if ((o_valve_sprinkler || o_valve_dripper) && i_tick) vt++;
         if (o_valve_sprinkler) zone = 0;
         if (o_valve_dripper) zone = 1;
         chk("da_vs_vd", o_dripper_active, o_valve_dripper);
         step();
         ok = o_zone_done;
      end
   endtask

   initial begin
      int z, pt, vt, pat, exp_z;
      bit ok;
      // reset state and single sprinkler request
      do_reset();
      i_level = 3'd5;
      chk("rst_state", o_state, 0);
      chk("rst_pump", o_pump_on, 0);
      chk("rst_vs", o_valve_sprinkler, 0);
      chk("rst_vd", o_valve_dripper, 0);
      chk("rst_done", o_zone_done, 0);
      chk("rst_low", o_low_water, 0);
      chk("rst_da", o_dripper_active, 0);
      i_req_sprinkler = 1'b1; i_tick = 1'b1;
      step(); chk("s1_vs_open", o_valve_sprinkler, 1); chk("s1_settle", o_state, 1); chk("s1_pump0", o_pump_on, 0);
      step(); chk("s1_pump_wait", o_pump_on, 0);
      step(); chk("s1_pump_on", o_pump_on, 1); chk("s1_water", o_state, 2);
      repeat (29) step();
      chk("s1_pump_29", o_pump_on, 1);
      step(); chk("s1_pump_off", o_pump_on, 0); chk("s1_purge", o_state, 3); chk("s1_vs_purge", o_valve_sprinkler, 1);
      step(); chk("s1_vs_hold", o_valve_sprinkler, 1); chk("s1_done_early", o_zone_done, 0);
      step(); chk("s1_vs_close", o_valve_sprinkler, 0); chk("s1_done", o_zone_done, 1); chk("s1_idle", o_state, 0);
      i_req_sprinkler = 1'b0;
      step(); chk("s1_done_pulse", o_zone_done, 0); chk("s1_idle2", o_state, 0);

      // contention: sprinkler, dripper, sprinkler
      do_reset();
      i_level = 3'd6; i_req_sprinkler = 1'b1; i_req_dripper = 1'b1;
      for (int g = 0; g < 3; g++) begin
         run_grant(1'b0, z, pt, vt, ok);
         chk("ct_finished", ok, 1);
         chk("ct_zone", z, (g == 1) ? 1 : 0);
         chk("ct_pump_ticks", pt, 30);
         chk("ct_open_ticks", vt, 34);
      end
      i_req_sprinkler = 1'b0; i_req_dripper = 1'b0;
      step(); chk("ct_idle", o_state, 0);

      // dripper request dropped during settle
      i_req_dripper = 1'b1;
      step(); chk("rd_vd", o_valve_dripper, 1); chk("rd_da", o_dripper_active, 1); chk("rd_settle", o_state, 1);
      step(); chk("rd_settle2", o_state, 1); chk("rd_pump0a", o_pump_on, 0);
      i_req_dripper = 1'b0;
      step(); chk("rd_purge", o_state, 3); chk("rd_pump0b", o_pump_on, 0); chk("rd_vd_purge", o_valve_dripper, 1);
      step(); chk("rd_purge2", o_state, 3); chk("rd_pump0c", o_pump_on, 0);
      step(); chk("rd_idle", o_state, 0); chk("rd_done", o_zone_done, 1); chk("rd_vd_close", o_valve_dripper, 0);
      step(); chk("rd_done_once", o_zone_done, 0);

      // low water during watering
      do_reset();
      i_level = 3'd6; i_req_sprinkler = 1'b1; i_tick = 1'b1;
      repeat (3) step();
      chk("lw_water", o_state, 2);
      repeat (2) step();
      i_level = 3'd1;
      step(); chk("lw_flag", o_low_water, 1); chk("lw_pump_still", o_pump_on, 1);
      step(); chk("lw_pump_off", o_pump_on, 0); chk("lw_purge", o_state, 3); chk("lw_vs_purge", o_valve_sprinkler, 1);
      step(); chk("lw_purge2", o_state, 3);
      step(); chk("lw_lockout", o_state, 4); chk("lw_done", o_zone_done, 1); chk("lw_vs_off", o_valve_sprinkler, 0);
      i_req_sprinkler = 1'b0; i_level = 3'd2;
      for (int k = 0; k < 3; k++) begin
         step(); chk("lw_hold_lock", o_state, 4); chk("lw_hold_flag", o_low_water, 1);
      end
      i_level = 3'd3;
      step(); chk("lw_clear", o_low_water, 0); chk("lw_still_lock", o_state, 4);
      step(); chk("lw_resume", o_state, 0);

      // asynchronous reset while watering
      i_req_sprinkler = 1'b1; i_level = 3'd6;
      repeat (3) step();
      chk("ar_water", o_pump_on, 1);
      #2 i_reset = 1'b0; m_low = 1'b0;
      #1;
      chk("ar_pump", o_pump_on, 0);
      chk("ar_vs", o_valve_sprinkler, 0);
      chk("ar_state", o_state, 0);
      i_req_dripper = 1'b1;
      i_reset = 1'b1;
      step(); chk("ar_spr_wins", o_valve_sprinkler, 1); chk("ar_vd", o_valve_dripper, 0);

      // random level, requests and ticks: hysteresis and output invariants
      for (int c = 0; c < 300; c++) begin
         i_level = 3'($urandom_range(0, 7));
         i_req_sprinkler = 1'($urandom_range(0, 1));
         i_req_dripper = 1'($urandom_range(0, 1));
         i_tick = 1'($urandom_range(0, 1));
         step();
         chk("rnd_low", o_low_water, m_low);
         chk("rnd_excl", o_valve_sprinkler & o_valve_dripper, 0);
         chk("rnd_da", o_dripper_active, o_valve_dripper);
         chk("rnd_pump_valve", o_pump_on & ~(o_valve_sprinkler | o_valve_dripper), 0);
      end

      // random request patterns with full-length grants: round-robin order model
      do_reset();
      i_level = 3'd6; m_last = 1;
      for (int r = 0; r < 6; r++) begin
         pat = int'($urandom_range(1, 3));
         i_req_sprinkler = pat[0];
         i_req_dripper = pat[1];
         exp_z = (pat == 3) ? 1 - m_last : ((pat == 2) ? 1 : 0);
         run_grant(1'b1, z, pt, vt, ok);
         chk("rr_finished", ok, 1);
         chk("rr_zone", z, exp_z);
         chk("rr_pump_ticks", pt, 30);
         chk("rr_open_ticks", vt, 34);
         m_last = exp_z;
      end
      i_req_sprinkler = 1'b0; i_req_dripper = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
